// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_ctrl CPU-side UART controller:
// register offsets, STATUS bit positions and FSM state encodings.
package uart_ctrl_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_NEMPTY = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_TX_ACTIVE = 5;

    localparam int CTL_RX_IRQ = 0;
    localparam int CTL_TX_IRQ = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_CLEAR = 1'b1
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Circular synchronous FIFO used for both the TX and RX byte queues.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_ctrl.sv
// CPU-side UART controller: TX/RX FIFOs, strobe/ready handshake FSMs.
// Optional interrupt and CONTROL register enabled by `UART_CTRL_IRQ_EN.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       write_enable,
    input  logic       read_enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_strobe,
    input  logic       uart_tx_busy,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_ready,
    output logic       uart_rx_ready_clear
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic [7:0] data_out_q, data_out_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_strobe_q, tx_strobe_d;
    logic       rx_clear_q, rx_clear_d;
    logic       overrun_q, overrun_d;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    status, ctrl_rd, cpu_rd_data;
    logic          status_rd, rx_overrun;
    logic          unused_counts;

    assign unused_counts = ^{tx_count, rx_count};

    assign tx_push = write_enable && (address == REG_DATA) && !tx_full;

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i   (raw_clk),
        .rst_i   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (data_in),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i   (raw_clk),
        .rst_i   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (uart_rx_data),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status               = 8'h00;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_NEMPTY] = !rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_TX_ACTIVE] = (tx_state_q != TX_IDLE);
    end

    // CPU read decode; a DATA read on an empty RX FIFO returns zero.
    always_comb begin
        cpu_rd_data = 8'h00;
        rx_pop      = 1'b0;
        status_rd   = 1'b0;
        if (read_enable) begin
            unique case (address)
                REG_DATA: begin
                    if (!rx_empty) begin
                        cpu_rd_data = rx_head;
                        rx_pop      = 1'b1;
                    end
                end
                REG_STATUS: begin
                    cpu_rd_data = status;
                    status_rd   = 1'b1;
                end
                REG_CTRL: cpu_rd_data = ctrl_rd;
                default:  cpu_rd_data = 8'h00;
            endcase
        end
        data_out_d = read_enable ? cpu_rd_data : data_out_q;
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        tx_strobe_d = 1'b0;
        tx_pop      = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !uart_tx_busy) begin
                    tx_data_d   = tx_head;
                    tx_strobe_d = 1'b1;
                    tx_pop      = 1'b1;
                    tx_state_d  = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: if (uart_tx_busy)  tx_state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!uart_tx_busy) tx_state_d = TX_IDLE;
            default:      tx_state_d = TX_IDLE;
        endcase
    end

    // A same-cycle CPU pop frees a slot, so a full FIFO can still accept.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_clear_d = 1'b0;
        rx_push    = 1'b0;
        rx_overrun = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (uart_rx_ready) begin
                    if (!rx_full || rx_pop) rx_push    = 1'b1;
                    else                    rx_overrun = 1'b1;
                    rx_clear_d = 1'b1;
                    rx_state_d = RX_CLEAR;
                end
            end
            RX_CLEAR: rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
        overrun_d = overrun_q;
        if (status_rd)  overrun_d = 1'b0;
        if (rx_overrun) overrun_d = 1'b1;
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            data_out_q  <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_strobe_q <= 1'b0;
            rx_clear_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            data_out_q  <= data_out_d;
            tx_data_q   <= tx_data_d;
            tx_strobe_q <= tx_strobe_d;
            rx_clear_q  <= rx_clear_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out            = data_out_q;
    assign uart_tx_data        = tx_data_q;
    assign uart_tx_strobe      = tx_strobe_q;
    assign uart_rx_ready_clear = rx_clear_q;

`ifdef UART_CTRL_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (write_enable && (address == REG_CTRL)) ctrl_d = data_in[1:0];
        irq_d = (ctrl_q[CTL_RX_IRQ] && !rx_empty)
              || (ctrl_q[CTL_TX_IRQ] && tx_empty);
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_rd = {6'b000000, ctrl_q};
    assign irq     = irq_q;
`else
    assign ctrl_rd = 8'h00;
    assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl with a behavioural uart handshake model.
module tb_uart_ctrl;

    logic       raw_clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = 2'd0;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       irq;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe;
    logic       uart_tx_busy;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_ready = 1'b0;
    logic       uart_rx_ready_clear;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int clear_cnt = 0;
    int busy_cnt = 0;
    logic hold_busy = 1'b0;
    logic mon_rd;
    logic prev_strobe = 1'b0;
    logic prev_clear = 1'b0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    uart_ctrl #(.DEPTH(16)) dut (
        .raw_clk             (raw_clk),
        .reset               (reset),
        .address             (address),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .data_in             (data_in),
        .data_out            (data_out),
        .irq                 (irq),
        .uart_tx_data        (uart_tx_data),
        .uart_tx_strobe      (uart_tx_strobe),
        .uart_tx_busy        (uart_tx_busy),
        .uart_rx_data        (uart_rx_data),
        .uart_rx_ready       (uart_rx_ready),
        .uart_rx_ready_clear (uart_rx_ready_clear)
    );

    always #5 raw_clk = ~raw_clk;

    // uart transmitter: busy for 5 cycles after it sees a strobe
    always @(posedge raw_clk) begin
        if (uart_tx_strobe) busy_cnt <= 5;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0) || hold_busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents an output.
    always @(posedge raw_clk) begin
        mon_rd = read_enable && !reset;
        #1;
        if (mon_rd) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else chk("rd_data", data_out, rd_q.pop_front());
        end
        if (uart_tx_strobe) begin
            strobe_cnt++;
            chk("strobe_while_busy", uart_tx_busy, 0);
            chk("strobe_width", prev_strobe, 0);
            if (tx_q.size() == 0) fail("tx_unexpected");
            else chk("tx_data", uart_tx_data, tx_q.pop_front());
        end
        if (uart_rx_ready_clear) begin
            clear_cnt++;
            chk("clear_width", prev_clear, 0);
        end
        prev_strobe = uart_tx_strobe;
        prev_clear  = uart_rx_ready_clear;
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge raw_clk);
        address = a;
        data_in = d;
        write_enable = 1'b1;
        @(negedge raw_clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        @(negedge raw_clk);
        address = a;
        read_enable = 1'b1;
        rd_q.push_back(exp);
        @(negedge raw_clk);
        read_enable = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        int c0;
        int lat;
        c0 = clear_cnt;
        lat = 0;
        @(negedge raw_clk);
        uart_rx_data = b;
        uart_rx_ready = 1'b1;
        while (clear_cnt == c0 && lat < 8) begin
            @(negedge raw_clk);
            lat++;
        end
        if (clear_cnt == c0) fail("rx_clear");
        else chk("rx_clear_lat", lat, 1);
        // keep the stale ready visible through the RX_CLEAR cycle
        @(negedge raw_clk);
        uart_rx_ready = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobe_cnt < n && k < budget) begin
            @(negedge raw_clk);
            k++;
        end
        if (strobe_cnt < n) fail("wait_strobes");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        repeat (2) @(negedge raw_clk);
        while (uart_tx_busy && k < 50) begin
            @(negedge raw_clk);
            k++;
        end
        if (uart_tx_busy) fail("wait_idle");
        repeat (3) @(negedge raw_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, data_out, 8'h00);
        chk({tag, "_tx_data"}, uart_tx_data, 8'h00);
        chk({tag, "_strobe"}, uart_tx_strobe, 1'b0);
        chk({tag, "_clear"}, uart_rx_ready_clear, 1'b0);
        chk({tag, "_irq"}, irq, 1'b0);
    endtask

    initial begin
        int base;
        logic [7:0] b;
        repeat (2) @(negedge raw_clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        rd(2'd1, 8'h02);

        // TX order
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h42);
        tx_q.push_back(8'h43);
        wr(2'd0, 8'h41);
        wr(2'd0, 8'h42);
        wr(2'd0, 8'h43);
        wait_strobes(3, 200);
        wait_idle();
        rd(2'd1, 8'h02);

        // RX single byte
        rx_byte(8'h5A);
        rd(2'd1, 8'h06);
        rd(2'd0, 8'h5A);
        rd(2'd1, 8'h02);

        // RX full and overrun
        for (int i = 0; i < 17; i++) begin
            b = 8'h80 + 8'(i);
            rx_byte(b);
        end
        rd(2'd1, 8'h1E);
        rd(2'd1, 8'h0E);
        for (int i = 0; i < 16; i++) begin
            b = 8'h80 + 8'(i);
            rd(2'd0, b);
        end
        rd(2'd0, 8'h00);
        rd(2'd1, 8'h02);

        // reserved register
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'h00);

        // TX full: line held busy
        base = strobe_cnt;
        @(negedge raw_clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'h10 + 8'(i);
            if (i < 16) tx_q.push_back(b);
            wr(2'd0, b);
        end
        rd(2'd1, 8'h01);
        hold_busy = 1'b0;
        wait_strobes(base + 16, 400);
        wait_idle();
        repeat (10) @(negedge raw_clk);
        chk("tx_full_count", strobe_cnt, base + 16);
        rd(2'd1, 8'h02);

        // reset while a byte is in flight
        base = strobe_cnt;
        tx_q.push_back(8'h77);
        wr(2'd0, 8'h77);
        wait_strobes(base + 1, 20);
        @(negedge raw_clk);
        hold_busy = 1'b1;
        reset = 1'b1;
        @(negedge raw_clk);
        chk_reset_outputs("mid");
        reset = 1'b0;
        tx_q.push_back(8'h99);
        wr(2'd0, 8'h99);
        repeat (6) @(negedge raw_clk);
        chk("no_strobe_busy", strobe_cnt, base + 1);
        rd(2'd1, 8'h00);
        hold_busy = 1'b0;
        wait_strobes(base + 2, 40);
        wait_idle();

`ifdef UART_CTRL_IRQ_EN
        wr(2'd2, 8'h01);
        rd(2'd2, 8'h01);
        rx_byte(8'h33);
        repeat (2) @(negedge raw_clk);
        chk("irq_set", irq, 1'b1);
        rd(2'd0, 8'h33);
        begin
            int k;
            k = 0;
            while (irq && k < 2) begin
                @(negedge raw_clk);
                k++;
            end
            chk("irq_clr", irq, 1'b0);
        end
`else
        wr(2'd2, 8'h03);
        rd(2'd2, 8'h00);
        rx_byte(8'h33);
        repeat (2) @(negedge raw_clk);
        chk("irq_off", irq, 1'b0);
        rd(2'd0, 8'h33);
`endif

        repeat (5) @(negedge raw_clk);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        chk("clear_total", clear_cnt, 19);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
